// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan path: nibble width, default scan
// timing and the per-slot display state.
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Width of one hex digit in the packed display value.
    localparam int NIBBLE_W = 4;

    // Default digit count and scan timing.
    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_SCAN_DIV     = 10000;
    localparam int DEF_BLANK_CYCLES = 100;

    // Phase of the current digit slot: anodes forced off, or digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/seg7_scan_mux_scan_timer.sv
// -----------------------------------------------------------------------------
// scan_timer
// Owns the scan position of the display: a cycle counter within each digit
// slot and the slot index within the frame. The decoded flags describe the
// position currently held in the counters. That position is the one the
// parent's output registers will present after the next clock edge.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset (counters to slot 0, cycle 0)
//   o_slot       current digit slot, 0..NUM_DIGITS-1
//   o_slot_wrap  counters sit on cycle 0 of a slot (cycle counter just wrapped)
//   o_frame_wrap counters sit on cycle 0 of slot 0 (first cycle of a frame)
//   o_in_blank   cycle counter is inside the blanking gap of the slot
// -----------------------------------------------------------------------------
module scan_timer
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int CW          = $clog2(SCAN_DIV),
    localparam int SW          = $clog2(NUM_DIGITS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [SW-1:0] o_slot,
    output logic          o_slot_wrap,
    output logic          o_frame_wrap,
    output logic          o_in_blank
);

    localparam logic [CW-1:0] CYC_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_cyc_cnt;
    logic [SW-1:0] r_slot;

    // Cycle counter wraps every SCAN_DIV cycles and carries into the slot index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc_cnt <= {CW{1'b0}};
            r_slot    <= {SW{1'b0}};
        end else if (r_cyc_cnt == CYC_LAST) begin
            r_cyc_cnt <= {CW{1'b0}};
            if (r_slot == SLOT_LAST) begin
                r_slot <= {SW{1'b0}};
            end else begin
                r_slot <= r_slot + SW'(1);
            end
        end else begin
            r_cyc_cnt <= r_cyc_cnt + CW'(1);
            r_slot    <= r_slot;
        end
    end

    assign o_slot       = r_slot;
    assign o_slot_wrap  = (r_cyc_cnt == {CW{1'b0}});
    assign o_frame_wrap = (r_cyc_cnt == {CW{1'b0}}) && (r_slot == {SW{1'b0}});
    assign o_in_blank   = (r_cyc_cnt < CYC_BLANK);

endmodule

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
// Time-multiplexed scan driver for a common-anode multi-digit 7-segment
// display. Input values are double-buffered (pending -> active at frame
// boundaries) so a frame never tears. Each digit slot starts with a blanking
// gap with all anodes off, then lights one anode. Leading zeros can be
// suppressed, and the suppression mask is frozen for the whole frame.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous active-high reset
//   i_value_in     packed nibbles, nibble 0 = rightmost digit
//   i_dp_in        decimal-point request per digit
//   i_load         one-cycle strobe capturing i_value_in / i_dp_in
//   i_lz_blank_en  leading-zero blanking enable (taken at frame start)
//   o_digit_out    nibble of the current slot for the seg7 decoder
//   o_dp_out       decimal point of the current slot
//   o_an_out       one-hot anode enable, active high
//   o_frame_start  one-cycle pulse on the first cycle of slot 0
//
// All outputs are registered. The output registers are loaded from the
// position held in scan_timer, so the outputs present that position one cycle
// later. The first cycle after reset release therefore shows slot 0, cycle 0
// with o_frame_start high.
// -----------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int SCAN_DIV     = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] i_value_in,
    input  logic [NUM_DIGITS-1:0]          i_dp_in,
    input  logic                           i_load,
    input  logic                           i_lz_blank_en,
    output logic [NIBBLE_W-1:0]            o_digit_out,
    output logic                           o_dp_out,
    output logic [NUM_DIGITS-1:0]          o_an_out,
    output logic                           o_frame_start
);

    localparam int VW = NUM_DIGITS * NIBBLE_W;
    localparam int SW = $clog2(NUM_DIGITS);

    // Digit k is suppressed when blanking is enabled, k > 0, and every nibble
    // from k up to the leftmost digit is zero. Digit 0 is never suppressed.
    function automatic logic [NUM_DIGITS-1:0] lz_suppress(
        input logic [VW-1:0] value,
        input logic          enable
    );
        logic                  zero_run;
        logic [NUM_DIGITS-1:0] mask;
        zero_run = 1'b1;
        mask     = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (value[k*NIBBLE_W +: NIBBLE_W] == {NIBBLE_W{1'b0}});
            mask[k]  = enable & zero_run;
        end
        return mask;
    endfunction

    // Scan position.
    logic [SW-1:0] w_slot;
    logic          w_slot_wrap;
    logic          w_frame_wrap;
    logic          w_in_blank;

    // Buffers.
    logic [VW-1:0]         r_active;
    logic [NUM_DIGITS-1:0] r_active_dp;
    logic [VW-1:0]         r_pending;
    logic [NUM_DIGITS-1:0] r_pending_dp;
    logic                  r_pending_valid;
    logic [NUM_DIGITS-1:0] r_lz_mask;

    // Active buffer contents as they will be once this edge is taken.
    logic [VW-1:0]         w_active_next;
    logic [NUM_DIGITS-1:0] w_active_dp_next;

    // Per-slot selections.
    logic [NIBBLE_W-1:0]   w_nibble;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an_onehot;

    // Output / FSM registers.
    slot_state_t           r_state;
    logic [NIBBLE_W-1:0]   r_digit_out;
    logic                  r_dp_out;
    logic [NUM_DIGITS-1:0] r_an_out;
    logic                  r_frame_start;

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_scan_timer (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .o_slot      (w_slot),
        .o_slot_wrap (w_slot_wrap),
        .o_frame_wrap(w_frame_wrap),
        .o_in_blank  (w_in_blank)
    );

    // Frame-boundary buffer swap: a load on the boundary bypasses pending,
    // otherwise a valid pending value is promoted.
    always_comb begin
        w_active_next    = r_active;
        w_active_dp_next = r_active_dp;
        if (w_frame_wrap) begin
            if (i_load) begin
                w_active_next    = i_value_in;
                w_active_dp_next = i_dp_in;
            end else if (r_pending_valid) begin
                w_active_next    = r_pending;
                w_active_dp_next = r_pending_dp;
            end else begin
                w_active_next    = r_active;
                w_active_dp_next = r_active_dp;
            end
        end else begin
            w_active_next    = r_active;
            w_active_dp_next = r_active_dp;
        end
    end

    // Buffer registers, pending flag, and the per-frame leading-zero mask.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active        <= {VW{1'b0}};
            r_active_dp     <= {NUM_DIGITS{1'b0}};
            r_pending       <= {VW{1'b0}};
            r_pending_dp    <= {NUM_DIGITS{1'b0}};
            r_pending_valid <= 1'b0;
            r_lz_mask       <= {NUM_DIGITS{1'b0}};
        end else begin
            r_active    <= w_active_next;
            r_active_dp <= w_active_dp_next;
            if (w_frame_wrap) begin
                r_pending_valid <= 1'b0;
                r_lz_mask       <= lz_suppress(w_active_next, i_lz_blank_en);
            end else if (i_load) begin
                r_pending       <= i_value_in;
                r_pending_dp    <= i_dp_in;
                r_pending_valid <= 1'b1;
            end else begin
                r_pending_valid <= r_pending_valid;
            end
        end
    end

    // Select the nibble, dp bit and anode for the slot about to be shown.
    // The mask read here was frozen at the frame boundary, and slot 0 is
    // always blank on that edge, so the one-cycle mask update is never visible.
    always_comb begin
        w_nibble    = {NIBBLE_W{1'b0}};
        w_dp        = 1'b0;
        w_an_onehot = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_slot == SW'(k)) begin
                w_nibble       = w_active_next[k*NIBBLE_W +: NIBBLE_W];
                w_dp           = w_active_dp_next[k];
                w_an_onehot[k] = ~r_lz_mask[k];
            end else begin
                w_an_onehot[k] = 1'b0;
            end
        end
    end

    // Slot FSM plus registered outputs; digit and dp track the slot during
    // BLANK as well so the decoder has settled before the anode turns on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= BLANK;
            r_digit_out   <= {NIBBLE_W{1'b0}};
            r_dp_out      <= 1'b0;
            r_an_out      <= {NUM_DIGITS{1'b0}};
            r_frame_start <= 1'b0;
        end else begin
            r_digit_out   <= w_nibble;
            r_dp_out      <= w_dp;
            r_frame_start <= w_frame_wrap;
            case (r_state)
                BLANK: begin
                    if (!w_in_blank) begin
                        r_state  <= SHOW;
                        r_an_out <= w_an_onehot;
                    end else begin
                        r_an_out <= {NUM_DIGITS{1'b0}};
                    end
                end
                SHOW: begin
                    if (w_slot_wrap) begin
                        r_state  <= BLANK;
                        r_an_out <= {NUM_DIGITS{1'b0}};
                    end else begin
                        r_an_out <= w_an_onehot;
                    end
                end
                default: begin
                    r_state  <= BLANK;
                    r_an_out <= {NUM_DIGITS{1'b0}};
                end
            endcase
        end
    end

    assign o_digit_out   = r_digit_out;
    assign o_dp_out      = r_dp_out;
    assign o_an_out      = r_an_out;
    assign o_frame_start = r_frame_start;

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed scan driver for a multi-digit common-anode 7-segment display. Sits between the hex display counter and the `seg7` decoder. It takes a packed multi-nibble value, double-buffers it so updates never tear mid-frame, and cycles one digit at a time. For each digit it presents the nibble for decoding together with a one-hot anode enable, and inserts a blanking gap between digits to suppress ghosting.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of display digits; legal range 2–8.
- `SCAN_DIV`, 10000: clock cycles per digit slot.
- `BLANK_CYCLES`, 100: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYCLES < SCAN_DIV.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `value_in` in 4*NUM_DIGITS: packed nibbles; nibble 0 is the rightmost digit.
- `dp_in` in NUM_DIGITS: decimal-point request per digit.
- `load` in 1: single-cycle strobe that captures `value_in` and `dp_in` into the pending buffer.
- `lz_blank_en` in 1: leading-zero blanking enable.
- `digit_out` out 4: nibble for the `seg7` decoder.
- `dp_out` out 1: decimal point for the current digit.
- `an_out` out NUM_DIGITS: one-hot anode enable, active high.
- `frame_start` out 1: one-cycle pulse on the first cycle of slot 0.

## Operation
- Buffers:
  - `load` writes the pending buffer and sets a `pending_valid` flag.
  - At every frame boundary (slot index wraps to 0), pending is copied to active only if `pending_valid` is set; the flag then clears.
  - A `load` asserted on the boundary cycle itself bypasses pending and goes straight into active for the new frame.
  - A later `load` within a frame overwrites pending (last write wins).
- Counters:
  - `cyc_cnt` counts 0..SCAN_DIV-1; width is clog2(SCAN_DIV).
  - `slot` counts 0..NUM_DIGITS-1 and advances when `cyc_cnt` wraps. `slot` itself wraps NUM_DIGITS-1 → 0.
- State machine, one pass per slot:
  - BLANK while `cyc_cnt < BLANK_CYCLES`: `an_out` = 0.
  - SHOW for the rest of the slot: `an_out` = 1 << slot, unless the digit is suppressed.
  - SHOW → BLANK on the `cyc_cnt` wrap.
- Leading-zero blanking:
  - Computed from the active buffer at frame start.
  - Digit k is suppressed when `lz_blank_en` = 1, k > 0, and nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps `an_out` = 0 for its whole slot.
- `digit_out` and `dp_out` always reflect the active nibble and dp bit of the current slot, including during BLANK, so the decoder settles before the anode turns on.

## Timing
- All outputs are registered.
- Reset values: `digit_out` = 0, `dp_out` = 0, `an_out` = 0, `frame_start` = 0. Active and pending buffers = 0, `pending_valid` = 0, `cyc_cnt` = 0, `slot` = 0, state = BLANK.
- First cycle after reset release is `cyc_cnt` = 0, slot 0, and `frame_start` = 1 on that cycle.
- `an_out` turns on exactly BLANK_CYCLES cycles after slot start. It stays on for SCAN_DIV − BLANK_CYCLES cycles.
- Frame period is NUM_DIGITS × SCAN_DIV cycles.
- Latency from `load` to display:
  - The new value appears at the next frame start.
  - If `load` coincides with the boundary cycle, it appears in that frame.
- `rst` asserted mid-frame: on the next edge, all outputs return to their reset values and any pending load is discarded.
- `lz_blank_en` is sampled at frame start only; a change mid-frame takes effect in the next frame.

## Structure
- Shared package `seg7_pkg`:
  - `NIBBLE_W` = 4.
  - Default values for `SCAN_DIV` and `BLANK_CYCLES`.
  - A `slot_state_t` enum with values BLANK and SHOW.
- Natural sub-module: `scan_timer`, which owns `cyc_cnt` and `slot`. It emits `slot_wrap`, `frame_wrap` and `in_blank`.
- The `seg7` decoder is instantiated by the parent top, not inside this block.

## Test plan
Bench parameters: NUM_DIGITS = 4, SCAN_DIV = 8, BLANK_CYCLES = 2.
- Reset, then `load` `value_in` = 16'h1A2F, with `lz_blank_en` = 0:
  - `an_out` sequence per frame is 0,0,0001×6, then 0,0,0010×6, 0,0,0100×6, 0,0,1000×6.
  - `digit_out` is F, 2, A, 1.
  - `frame_start` pulses every 32 cycles.
- `load` 16'h0005 with `lz_blank_en` = 1 → only digit 0 is lit, showing 5; slots 1–3 keep `an_out` = 0 throughout.
- `load` 16'h1111 mid-frame at slot 2, then `load` 16'h2222 at slot 3 → remainder of the current frame still shows the old value; next frame shows 2222.
- `load` 16'h3333 on the exact frame-boundary cycle → that same frame shows 3333.
- `dp_in` = 4'b0100 → `dp_out` = 1 only during slot 2.
- Assert `rst` at slot 2, cycle 5 → next edge gives `an_out` = 0 and `digit_out` = 0. After release, the first frame shows 0000 and `frame_start` = 1 on the first cycle.
